// File: rtl/rom_addr_seq.sv
// ROM address sequencer with auto/pause stepping and latency-compensated read capture.
// Optional down-count support via the ROM_SEQ_DIR_EN macro (adds the dir input).
module rom_addr_seq #(
  parameter int ADDR_W   = 8,
  parameter int ADDR_MAX = 255,
  parameter int STEP_CNT = 25_000_000,
  parameter int ROM_LAT  = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              key_flag,
  input  logic              step_flag,
`ifdef ROM_SEQ_DIR_EN
  input  logic              dir,
`endif
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_out,
  output logic              data_vld,
  output logic              mode
);

  localparam int CNT_W = $clog2(STEP_CNT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STEP_CNT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);

  typedef enum logic {AUTO = 1'b0, PAUSE = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               adv;
  logic               dir_dn;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               first_fetch;
  logic [ROM_LAT-1:0] tok;

`ifdef ROM_SEQ_DIR_EN
  assign dir_dn = dir;
`else
  assign dir_dn = 1'b0;
`endif

  assign mode = state;

  // A key press always wins over both the terminal count and a manual step.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    adv       = 1'b0;
    unique case (state)
      AUTO: begin
        if (key_flag) begin
          state_nxt = PAUSE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          adv     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PAUSE: begin
        cnt_nxt = '0;
        if (key_flag)       state_nxt = AUTO;
        else if (step_flag) adv       = 1'b1;
      end
      default: begin
        state_nxt = AUTO;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    addr_nxt = addr;
    if (dir_dn) addr_nxt = (addr == '0) ? ADDR_LAST : addr - ADDR_W'(1);
    else        addr_nxt = (addr == ADDR_LAST) ? '0 : addr + ADDR_W'(1);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= AUTO;
      cnt   <= '0;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (adv) addr <= addr_nxt;
    end
  end

  // One token per address update; a token leaving the last stage captures rom_q.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      first_fetch <= 1'b1;
      tok         <= '0;
      data_vld    <= 1'b0;
      data_out    <= '0;
    end else begin
      first_fetch <= 1'b0;
      tok         <= (tok << 1) | ROM_LAT'(adv | first_fetch);
      data_vld    <= tok[ROM_LAT-1];
      if (tok[ROM_LAT-1]) data_out <= rom_q;
    end
  end

endmodule

// File: tb/tb_rom_addr_seq.sv
// Self-checking bench for rom_addr_seq: directed scenarios plus random key/step traffic
// against a cycle-indexed behavioural model with a capture scoreboard.
module tb_rom_addr_seq;

  localparam int ADDR_W   = 8;
  localparam int ADDR_MAX = 5;
  localparam int STEP_CNT = 4;
  localparam int ROM_LAT  = 2;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic              key_flag = 1'b0;
  logic              step_flag = 1'b0;
  logic              dir = 1'b0;
  logic [7:0]        rom_q = 8'h00;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_out;
  logic              data_vld;
  logic              mode;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         due;
    logic [7:0] val;
  } cap_t;

  cap_t       capq[$];
  int         m_addr, m_mode, m_start, m_edge;
  logic [7:0] m_dout;

  rom_addr_seq #(
    .ADDR_W(ADDR_W), .ADDR_MAX(ADDR_MAX), .STEP_CNT(STEP_CNT), .ROM_LAT(ROM_LAT)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .key_flag (key_flag),
    .step_flag(step_flag),
`ifdef ROM_SEQ_DIR_EN
    .dir      (dir),
`endif
    .rom_q    (rom_q),
    .addr     (addr),
    .data_out (data_out),
    .data_vld (data_vld),
    .mode     (mode)
  );

  always #5 sys_clk = ~sys_clk;

  // ROM: q reflects the presented address one clock later (valid in the 2nd cycle).
  always @(posedge sys_clk) rom_q <= addr + 8'h10;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge: counter phase derived from cycles since the last auto restart.
  task automatic model_edge(input bit k, input bit s, input bit d);
    bit adv = 1'b0;
    if (m_mode == 0) begin
      if (k) m_mode = 1;
      else if (((m_edge - m_start) % STEP_CNT) == STEP_CNT - 1) adv = 1'b1;
    end else begin
      if (k) begin
        m_mode  = 0;
        m_start = m_edge + 1;
      end else if (s) adv = 1'b1;
    end
    if (adv) begin
      if (d) m_addr = (m_addr == 0) ? ADDR_MAX : m_addr - 1;
      else   m_addr = (m_addr == ADDR_MAX) ? 0 : m_addr + 1;
      capq.push_back('{m_edge + ROM_LAT, 8'(m_addr + 16)});
    end
  endtask

  task automatic apply_stimulus(input bit k, input bit s, input bit d);
    bit   exp_vld;
    bit   d_eff;
`ifdef ROM_SEQ_DIR_EN
    d_eff = d;
`else
    d_eff = 1'b0;
`endif
    key_flag  = k;
    step_flag = s;
    dir       = d;
    @(posedge sys_clk);
    model_edge(k, s, d_eff);
    #1;
    exp_vld = 1'b0;
    if (capq.size() > 0 && capq[0].due == m_edge) begin
      exp_vld = 1'b1;
      m_dout  = capq[0].val;
      void'(capq.pop_front());
    end
    check_output("addr", 32'(addr), 32'(m_addr));
    check_output("mode", 32'(mode), 32'(m_mode));
    check_output("data_vld", 32'(data_vld), 32'(exp_vld));
    check_output("data_out", 32'(data_out), 32'(m_dout));
    m_edge++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_output("rst_addr", 32'(addr), 32'd0);
    check_output("rst_data_out", 32'(data_out), 32'd0);
    check_output("rst_data_vld", 32'(data_vld), 32'd0);
    check_output("rst_mode", 32'(mode), 32'd0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    key_flag  = 1'b0;
    step_flag = 1'b0;
    rst       = 1'b0;
    m_addr  = 0;
    m_mode  = 0;
    m_start = 0;
    m_edge  = 0;
    m_dout  = 8'h00;
    capq.delete();
    capq.push_back('{ROM_LAT, 8'h10});
  endtask

  initial begin
    bit reached;
    int saved_addr;

    do_reset();

    // Auto stepping through a full wrap of the address range.
    repeat (26) apply_stimulus(1'b0, 1'b0, 1'b0);

    // Key on the terminal count pauses without advancing.
    reached = 1'b0;
    for (int i = 0; i < STEP_CNT + 1 && !reached; i++) begin
      if (((m_edge - m_start) % STEP_CNT) == STEP_CNT - 1) reached = 1'b1;
      else apply_stimulus(1'b0, 1'b0, 1'b0);
    end
    check_output("reach_terminal", 32'(reached), 32'd1);
    saved_addr = m_addr;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("key_wins_addr", 32'(addr), 32'(saved_addr));
    check_output("key_pause_mode", 32'(mode), 32'd1);
    repeat (20) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("pause_hold_addr", 32'(addr), 32'(saved_addr));

    // Manual steps up to ADDR_MAX, then wrap to 0.
    for (int i = 0; i < ADDR_MAX + 1 && m_addr != ADDR_MAX; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("reach_addr_max", 32'(addr), 32'(ADDR_MAX));
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("wrap_addr", 32'(addr), 32'd0);
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("wrap_data", 32'(data_out), 32'h10);

    // Key and step together: key wins, back to auto.
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("key_step_mode", 32'(mode), 32'd0);
    check_output("key_step_addr", 32'(addr), 32'd0);

    // Back-to-back manual steps keep every capture.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("b2b_last_data", 32'(data_out), 32'h13);

    // Reset with a token in flight.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (4) apply_stimulus(1'b0, 1'b0, 1'b0);

`ifdef ROM_SEQ_DIR_EN
    // Down-counting from 0 wraps to ADDR_MAX; dir toggles mid-run.
    do_reset();
    repeat (14) apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("dir_down_addr", 32'(addr), 32'd3);
    repeat (8) apply_stimulus(1'b0, 1'b0, 1'b0);
    repeat (8) apply_stimulus(1'b0, 1'b0, 1'b1);
`endif

    // Random key/step/dir traffic.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(bit'($urandom_range(15) == 0), bit'($urandom_range(3) == 0),
                     bit'($urandom_range(1)));
      if (i == 200) do_reset();
    end
    repeat (4) apply_stimulus(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_addr_seq.md
Name: rom_addr_seq

Overview:
Address sequencer and read-data capture stage sitting directly upstream of the 256x8 ROM and between the ROM and the seven-segment display driver. Steps the ROM address automatically at a fixed rate, or manually from touch-key pulses, and compensates for the ROM read latency. Presents a stable, latched ROM data byte plus a valid strobe to the display path.

Parameters:
ADDR_W, 8, ROM address width.
ADDR_MAX, 255, last address before wrap; must be <= 2^ADDR_W-1.
STEP_CNT, 25_000_000, sys_clk cycles per auto step (0.5 s at 50 MHz); must be >= 2.
ROM_LAT, 2, ROM read latency in cycles from addr change to valid q (1..4).

Ports:
sys_clk    in   1       system clock, all logic rising-edge
rst        in   1       asynchronous, active-high reset
key_flag   in   1       1-cycle pulse from touch-key block; toggles mode
step_flag  in   1       1-cycle pulse; manual +1 step, honoured in PAUSE only
rom_q      in   8       ROM read data
addr       out  ADDR_W  ROM address, registered
data_out   out  8       latched ROM byte for display
data_vld   out  1       1-cycle pulse when data_out updates
mode       out  1       0 = AUTO, 1 = PAUSE

Behaviour:
- Reset (async assert, sync release effect): addr=0, data_out=0, data_vld=0, mode=0 (AUTO), step counter=0, capture pipeline cleared except a fetch for addr 0 is issued on the first clock after reset release.
- Two states: AUTO, PAUSE; mode output = state.
- AUTO: counter counts 0..STEP_CNT-1; on the cycle counter==STEP_CNT-1, counter->0 and addr advances by 1. step_flag ignored.
- AUTO + key_flag: -> PAUSE next cycle; counter cleared; addr holds, no advance that cycle even if counter is terminal (key wins).
- PAUSE: counter held at 0; step_flag advances addr by 1 next cycle.
- PAUSE + key_flag: -> AUTO; counter restarts at 0; if step_flag is in the same cycle, key wins and no step occurs.
- Wrap: advance from ADDR_MAX -> 0. Never outputs addr > ADDR_MAX.
- Capture: every addr update (including the post-reset fetch) injects a token into a ROM_LAT-deep shift register. When a token exits, data_out <= rom_q and data_vld=1 that same cycle. Latency is exactly ROM_LAT cycles from the first cycle the new addr is visible to data_vld.
- Back-to-back addr updates with in-flight tokens: all tokens are kept, each capture is in order, and no token is dropped or merged.
- data_out holds its value between captures. Mode changes do not affect in-flight tokens.
- rst asserted mid-operation: all state returns to reset values immediately; in-flight tokens are discarded.

Optional Feature:
Macro ROM_SEQ_DIR_EN.
- Defined: adds input port dir (1 bit). dir=1 makes every advance (auto or manual) a -1 step, with wrap 0 -> ADDR_MAX. dir=0 keeps the +1 behaviour. dir is sampled on the advance cycle. A direction change never alters in-flight captures.
- Undefined: no dir port; up-count only. Behaviour is otherwise identical.

Test Plan:
(Bench params: STEP_CNT=4, ROM_LAT=2, ADDR_MAX=5. ROM model: q = addr+8'h10, 2-cycle latency.)
- Release rst, no keys -> addr=0 then data_out=8'h10 with data_vld 2 cycles after release. addr steps 1,2,3,4,5,0 every 4 cycles. Each step is followed by data_vld+data_out=addr+8'h10 exactly 2 cycles later.
- key_flag at counter==3 in AUTO -> mode=1, addr does not advance. Then 20 idle cycles -> addr constant, no data_vld.
- In PAUSE at addr=5, step_flag -> addr=0 next cycle, data_out=8'h10 two cycles later. key_flag+step_flag same cycle -> mode=0, addr unchanged, counter restarts.
- In PAUSE, step_flag on 3 consecutive cycles -> addr 1,2,3 back-to-back. data_vld high 3 consecutive cycles with data_out 8'h11,8'h12,8'h13.
- Assert rst one cycle after an addr update (token in flight) -> no data_vld emitted. All outputs return to 0, and the post-release fetch of addr 0 occurs.
- ROM_SEQ_DIR_EN defined, dir=1, from addr=0 in AUTO -> addr 5,4,3 and data_out 8'h15,8'h14,8'h13. Toggling dir mid-run affects only the next advance.
